fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle processor core. It generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch queue. It presents one instruction plus its PC per cycle to the core's decode input through a valid/ready handshake. Taken branches and jumps from the core redirect the fetch stream, flush the queue and discard stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus width, default reset PC and the
// prefetch queue entry layout, which decode reuses for its input register.
package fetch_unit_pkg;

  localparam int BUS_WIDTH = 32;
  localparam logic [BUS_WIDTH-1:0] RESET_PC_DEF = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [BUS_WIDTH-1:0] pc;
    logic [BUS_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Word-align a PC by clearing the two byte-offset bits.
  function automatic logic [BUS_WIDTH-1:0] align_pc(input logic [BUS_WIDTH-1:0] pc);
    return pc & ~BUS_WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch entries with a
// single-cycle flush. Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int                   DEPTH    = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  localparam int                  AW       = $clog2(DEPTH),
  localparam int                  CW       = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]            rd_ptr, wr_ptr;
  logic                     push_ok, pop_ok;

  // Never overrun or underrun, even if a caller misbehaves.
  assign push_ok = push && (count != FULL_C);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage and pointers; entries reset so an empty head reads {RESET_PC, 0}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].pc   <= RESET_PC;
        mem[i].inst <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential address generation, credit-limited
// request issue, in-order response capture into a prefetch queue and
// redirect handling with stale-response discard.
// Optional build macro FETCH_MISALIGN_CHK_EN adds misalign_err and halts
// fetch on a misaligned redirect target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [BUS_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                   DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [BUS_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [BUS_WIDTH-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                 misalign_err,
`endif
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [BUS_WIDTH-1:0] inst,
  output logic [BUS_WIDTH-1:0] inst_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [BUS_WIDTH-1:0] fpc, rpc, redirect_tgt;
  logic [CW-1:0]        count, outst, drop;
  logic [CW:0]          inflight;
  logic                 req_fire, rsp_keep, pop, halt;
  fetch_entry_t         push_entry, head;

  assign redirect_tgt = align_pc(redirect_pc);
  assign inflight     = {1'b0, count} + {1'b0, outst};

`ifdef FETCH_MISALIGN_CHK_EN
  assign halt = misalign_err;

  // Sticky error: a misaligned redirect stops fetch until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

  // Queued plus outstanding is capped at DEPTH so every response has a slot.
  assign imem_req_valid = rst && !redirect_valid && !halt && (inflight < DEPTH_C);
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign pop            = inst_valid && inst_ready;

  // Fetch PC advances per accepted request, response PC per kept response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= RESET_PC;
      rpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= redirect_tgt;
      rpc <= redirect_tgt;
    end else begin
      if (req_fire) fpc <= fpc + BUS_WIDTH'(4);
      if (rsp_keep) rpc <= rpc + BUS_WIDTH'(4);
    end
  end

  // Outstanding and stale-drop counters; a redirect marks everything in flight stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst <= '0;
      drop  <= '0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid)                     drop <= outst - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)  drop <= drop - 1'b1;
    end
  end

  assign push_entry.pc   = rpc;
  assign push_entry.inst = imem_rsp_data;

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bench memory model with configurable
// latency answers requests in order; a queue of expected PCs is filled as the
// memory accepts requests and drained/compared as the core consumes them.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_err   (misalign_err),
`endif
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int          n_checks, n_pass;
  int          lat, cyc, pops, accs;
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fpc;
  logic [31:0] pc_log [8];
  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_addr, s_inst_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One clock: sample mid-cycle, score pops/requests, then drive next response.
  task automatic step();
    pend_t       p;
    logic [31:0] e;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_addr       = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) check("spurious_pop", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst", inst, mem_data(e));
      end
      if (pops < 8) pc_log[pops] = inst_pc;
      pops++;
    end
    if (redirect_valid) begin
      check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_fpc = redirect_pc & ~32'h3;
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_fpc);
      exp_q.push_back(exp_fpc);
      exp_fpc += 32'd4;
      p.addr = imem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      accs++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(p.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Memory is reset together with the fetch unit, so pending responses vanish.
  task automatic do_reset();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend.delete();
    exp_q.delete();
    exp_fpc = 32'h0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_count", 32'(dut.count), 32'd0);
    check("rst_outst", 32'(dut.outst), 32'd0);
    check("rst_drop", 32'(dut.drop), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    cyc  = 0;
    accs = 0;
    pops = 0;
  endtask

  // Run until the first instruction is consumed (bounded), return its PC check.
  task automatic wait_first_pop(input string tag, input logic [31:0] expv);
    pops = 0;
    for (int i = 0; i < 40 && pops == 0; i++) step();
    check({tag, "_seen"}, 32'(pops > 0), 32'd1);
    check(tag, pc_log[0], expv);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    rst = 1'b1;
    #2;

    // Streaming, 1-cycle memory: first-instruction latency and throughput.
    do_reset();
    step();
    check("t1_c0_req_valid", 32'(s_req_valid), 32'd1);
    check("t1_c0_addr", s_addr, 32'h0);
    check("t1_c0_inst_valid", 32'(s_inst_valid), 32'd0);
    step();
    check("t1_c1_addr", s_addr, 32'h4);
    check("t1_c1_inst_valid", 32'(s_inst_valid), 32'd0);
    step();
    check("t1_c2_addr", s_addr, 32'h8);
    check("t1_c2_inst_valid", 32'(s_inst_valid), 32'd1);
    check("t1_c2_inst_pc", s_inst_pc, 32'h0);
    pops = 0;
    repeat (8) step();
    check("t1_throughput", 32'(pops), 32'd8);

    // Core stalled: credits cap acceptance at DEPTH, then drain in order.
    inst_ready = 1'b0;
    do_reset();
    repeat (10) step();
    check("t2_accepts", 32'(accs), 32'd4);
    check("t2_req_valid_low", 32'(s_req_valid), 32'd0);
    check("t2_count_full", 32'(dut.count), 32'd4);
    inst_ready = 1'b1;
    step();
    check("t2_first_pop_pc", s_inst_pc, 32'h0);
    check("t2_still_blocked", 32'(s_req_valid), 32'd0);
    step();
    check("t2_resume_valid", 32'(s_req_valid), 32'd1);
    check("t2_resume_addr", s_addr, 32'h10);
    repeat (6) step();

    // 3-cycle memory, redirect with two requests in flight.
    lat = 3;
    do_reset();
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    check("t3_drop", 32'(dut.drop), 32'd2);
    check("t3_outst", 32'(dut.outst), 32'd2);
    check("t3_fpc", dut.fpc, 32'h100);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_first_pop("t3_first_pc", 32'h100);
    check("t3_drop_drained", 32'(dut.drop), 32'd0);

    // Redirect coinciding with a response and a pop.
    lat = 2;
    do_reset();
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    check("t4_head_valid_at_redirect", 32'(s_inst_valid), 32'd1);
    check("t4_count_flushed", 32'(dut.count), 32'd0);
    check("t4_drop", 32'(dut.drop), 32'd1);
    check("t4_outst", 32'(dut.outst), 32'd1);
    redirect_valid = 1'b0;
    step();
    check("t4_empty_next", 32'(s_inst_valid), 32'd0);
    wait_first_pop("t4_first_pc", 32'h200);

    // PC wrap at the top of the address space.
    lat = 1;
    do_reset();
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    pops = 0;
    for (int i = 0; i < 40 && pops < 3; i++) step();
    check("t5_pops", 32'(pops >= 3), 32'd1);
    check("t5_pc0", pc_log[0], 32'hFFFF_FFF8);
    check("t5_pc1", pc_log[1], 32'hFFFF_FFFC);
    check("t5_pc2", pc_log[2], 32'h0000_0000);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check("t6_misalign_set", 32'(misalign_err), 32'd1);
    accs = 0;
    repeat (10) step();
    check("t6_no_requests", 32'(accs), 32'd0);
    check("t6_req_valid_low", 32'(s_req_valid), 32'd0);
    check("t6_inst_valid_low", 32'(s_inst_valid), 32'd0);
    check("t6_misalign_sticky", 32'(misalign_err), 32'd1);
`else
    wait_first_pop("t6_first_pc", 32'h100);
    repeat (3) step();
`endif

    // Reset in the middle of activity clears everything at once.
    do_reset();
    step();
    check("t7_restart_addr", s_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
